cog_ctr_seq: RTL and testbench

//  Step sequencer for one cog counter: plays a stored profile of (frq, duration) steps

---
 rtl/cog_ctr_seq.sv | 166 ++++++++++++++++
 tb/tb_cog_ctr_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cog_ctr_seq.sv
`default_nettype none
// ============================================================================
// cog_ctr_seq : profile step sequencer sharing the cog counter write port
// Revision    : 1.0
// ============================================================================
module cog_ctr_seq #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int DURW  = 16
) (
   input  logic            clk_cog,
   input  logic            nres,
   input  logic            ena,
   input  logic            prog_we,
   input  logic [AW-1:0]   prog_addr,
   input  logic [31:0]     prog_frq,
   input  logic [DURW-1:0] prog_dur,
   input  logic [31:0]     cfg_ctr,
   input  logic [AW-1:0]   cfg_last,
   input  logic            cfg_loop,
   input  logic            start,
   input  logic            stop,
   input  logic            cog_setctr,
   input  logic            cog_setfrq,
   input  logic            cog_setphs,
   input  logic [31:0]     cog_data,
   output logic            setctr,
   output logic            setfrq,
   output logic            setphs,
   output logic [31:0]     data,
   output logic            busy,
   output logic            done,
   output logic [AW-1:0]   step
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      S_CTR  = 3'd1,
      S_PHS  = 3'd2,
      S_FRQ  = 3'd3,
      S_HOLD = 3'd4,
      S_END  = 3'd5
   } state_t;

   state_t          r_state;
   state_t          w_adv_state;
   logic [AW-1:0]   w_adv_step;
   logic [DURW-1:0] r_hold;
   logic [DURW-1:0] w_dur_m1;
   logic            r_end_flag;
   logic            w_cog;

   logic [31:0]     r_frq_mem [DEPTH];
   logic [DURW-1:0] r_dur_mem [DEPTH];

   // Profile storage has no reset; entries are defined only once written.
   always_ff @(posedge clk_cog) begin
      if (prog_we) begin
         r_frq_mem[prog_addr] <= prog_frq;
         r_dur_mem[prog_addr] <= prog_dur;
      end
   end

   assign w_cog    = cog_setctr | cog_setfrq | cog_setphs;
   assign w_dur_m1 = (r_dur_mem[step] == '0) ? '0 : r_dur_mem[step] - DURW'(1);

   always_comb begin
      w_adv_state = S_FRQ;
      w_adv_step  = step + AW'(1);
      if (step == cfg_last) begin
         if (cfg_loop) begin
            w_adv_step = '0;
         end else begin
            w_adv_state = S_END;
            w_adv_step  = step;
         end
      end
   end

   always_ff @(posedge clk_cog or negedge nres) begin
      if (!nres) begin
         r_state    <= IDLE;
         r_hold     <= '0;
         r_end_flag <= 1'b0;
         setctr     <= 1'b0;
         setfrq     <= 1'b0;
         setphs     <= 1'b0;
         data       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         step       <= '0;
      end else begin
         setctr     <= cog_setctr;
         setfrq     <= cog_setfrq;
         setphs     <= cog_setphs;
         data       <= w_cog ? cog_data : 32'd0;
         done       <= r_end_flag;
         r_end_flag <= 1'b0;

         if (!ena) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
         end else if (!w_cog) begin
            // A cog write in this cycle leaves the whole FSM frozen so the
            // pending sequencer write is simply reissued next cycle.
            case (r_state)
               IDLE: begin
                  if (start && !stop) begin
                     r_state <= S_CTR;
                     step    <= '0;
                     busy    <= 1'b1;
                  end
               end
               S_CTR: begin
                  setctr  <= 1'b1;
                  data    <= cfg_ctr;
                  r_state <= stop ? S_END : S_PHS;
               end
               S_PHS: begin
                  setphs  <= 1'b1;
                  data    <= 32'd0;
                  r_state <= stop ? S_END : S_FRQ;
               end
               S_FRQ: begin
                  setfrq <= 1'b1;
                  data   <= r_frq_mem[step];
                  if (stop) begin
                     r_state <= S_END;
                  end else if (w_dur_m1 == '0) begin
                     r_state <= w_adv_state;
                     step    <= w_adv_step;
                  end else begin
                     r_hold  <= w_dur_m1;
                     r_state <= S_HOLD;
                  end
               end
               S_HOLD: begin
                  if (stop) begin
                     r_state <= S_END;
                  end else if (r_hold <= DURW'(1)) begin
                     r_hold  <= '0;
                     r_state <= w_adv_state;
                     step    <= w_adv_step;
                  end else begin
                     r_hold <= r_hold - DURW'(1);
                  end
               end
               S_END: begin
                  setctr     <= 1'b1;
                  data       <= 32'd0;
                  r_state    <= IDLE;
                  busy       <= 1'b0;
                  r_end_flag <= 1'b1;
               end
               default: begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cog_ctr_seq.sv
`default_nettype none
// Scoreboard bench for cog_ctr_seq: directed runs push cycle-stamped expected
// writes; a negedge monitor pops and compares every write/done it observes.
module tb_cog_ctr_seq;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int DURW  = 16;
   localparam logic [31:0] CFG_CTR = 32'h1234_5678;
   localparam logic [3:0] K_DONE = 4'b1000;
   localparam logic [3:0] K_CTR  = 4'b0100;
   localparam logic [3:0] K_FRQ  = 4'b0010;
   localparam logic [3:0] K_PHS  = 4'b0001;

   logic            clk_cog = 1'b0;
   logic            nres = 1'b0, ena = 1'b0;
   logic            prog_we = 1'b0;
   logic [AW-1:0]   prog_addr = '0;
   logic [31:0]     prog_frq = '0;
   logic [DURW-1:0] prog_dur = '0;
   logic [31:0]     cfg_ctr = CFG_CTR;
   logic [AW-1:0]   cfg_last = '0;
   logic            cfg_loop = 1'b0;
   logic            start = 1'b0, stop = 1'b0;
   logic            cog_setctr = 1'b0, cog_setfrq = 1'b0, cog_setphs = 1'b0;
   logic [31:0]     cog_data = '0;
   logic            setctr, setfrq, setphs, busy, done;
   logic [31:0]     data;
   logic [AW-1:0]   step;

   cog_ctr_seq #(.DEPTH(DEPTH), .AW(AW), .DURW(DURW)) dut (
      .clk_cog(clk_cog), .nres(nres), .ena(ena),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_frq(prog_frq), .prog_dur(prog_dur),
      .cfg_ctr(cfg_ctr), .cfg_last(cfg_last), .cfg_loop(cfg_loop),
      .start(start), .stop(stop),
      .cog_setctr(cog_setctr), .cog_setfrq(cog_setfrq), .cog_setphs(cog_setphs),
      .cog_data(cog_data),
      .setctr(setctr), .setfrq(setfrq), .setphs(setphs), .data(data),
      .busy(busy), .done(done), .step(step)
   );

   always #5 clk_cog = ~clk_cog;

   int cyc = 0;
   always @(posedge clk_cog) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [35:0] word;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;

   task automatic push(input int c, input logic [3:0] k, input logic [31:0] d);
      exp_t e;
      e.cyc  = c;
      e.word = {k, d};
      q.push_back(e);
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Monitor: every observed write or done must match the oldest expectation.
   logic [35:0] mon_w;
   exp_t        mon_e;
   always @(negedge clk_cog) begin
      if (nres) begin
         mon_w = {done, setctr, setfrq, setphs, data};
         while (q.size() > 0 && q[0].cyc < cyc) begin
            mon_e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_event: expected %h at cycle %0d, not seen", mon_e.word, mon_e.cyc);
         end
         if (done | setctr | setfrq | setphs) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_event: got %h at cycle %0d, expected none", mon_w, cyc);
            end else begin
               mon_e = q.pop_front();
               if (mon_e.cyc != cyc || mon_e.word !== mon_w) begin
                  failures++;
                  $display("FAIL event: got %h at cycle %0d expected %h at cycle %0d",
                           mon_w, cyc, mon_e.word, mon_e.cyc);
               end
            end
         end
      end
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk_cog);
   endtask

   task automatic prog(input int a, input logic [31:0] f, input logic [DURW-1:0] d);
      prog_we   = 1'b1;
      prog_addr = AW'(a);
      prog_frq  = f;
      prog_dur  = d;
      @(negedge clk_cog);
      prog_we   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk_cog);
      start = 1'b0;
   endtask

   task automatic push_basic(input int c0);
      push(c0 + 2,  K_CTR,  CFG_CTR);
      push(c0 + 3,  K_PHS,  32'd0);
      push(c0 + 4,  K_FRQ,  32'd100);
      push(c0 + 8,  K_FRQ,  32'd200);
      push(c0 + 9,  K_FRQ,  32'd300);
      push(c0 + 10, K_CTR,  32'd0);
      push(c0 + 11, K_DONE, 32'd0);
   endtask

   int c0, c1;

   initial begin
      repeat (3) @(negedge clk_cog);
      check("reset_outputs", 64'({setctr, setfrq, setphs, done, busy, step, data}), 64'd0);
      nres = 1'b1;
      ena  = 1'b1;
      @(negedge clk_cog);
      prog(0, 32'd100, 16'd4);
      prog(1, 32'd200, 16'd1);
      prog(2, 32'd300, 16'd0);
      cfg_last = 3'd2;
      cfg_loop = 1'b0;

      // single pass
      c0 = cyc;
      push_basic(c0);
      pulse_start();
      wait_cyc(c0 + 5);
      check("busy_running", 64'(busy), 64'd1);
      wait_cyc(c0 + 12);
      check("busy_after_done", 64'(busy), 64'd0);

      // looping until stop lands in a hold
      cfg_loop = 1'b1;
      c0 = cyc;
      push(c0 + 2,  K_CTR, CFG_CTR);
      push(c0 + 3,  K_PHS, 32'd0);
      push(c0 + 4,  K_FRQ, 32'd100);
      push(c0 + 8,  K_FRQ, 32'd200);
      push(c0 + 9,  K_FRQ, 32'd300);
      push(c0 + 10, K_FRQ, 32'd100);
      push(c0 + 14, K_FRQ, 32'd200);
      push(c0 + 15, K_FRQ, 32'd300);
      push(c0 + 16, K_FRQ, 32'd100);
      push(c0 + 19, K_CTR, 32'd0);
      push(c0 + 20, K_DONE, 32'd0);
      pulse_start();
      wait_cyc(c0 + 17);
      stop = 1'b1;
      @(negedge clk_cog);
      stop = 1'b0;
      cfg_loop = 1'b0;
      wait_cyc(c0 + 22);
      check("busy_after_stop", 64'(busy), 64'd0);

      // cog write collides with the second setfrq
      c0 = cyc;
      push(c0 + 2,  K_CTR, CFG_CTR);
      push(c0 + 3,  K_PHS, 32'd0);
      push(c0 + 4,  K_FRQ, 32'd100);
      push(c0 + 8,  K_FRQ, 32'h0000_DEAD);
      push(c0 + 9,  K_FRQ, 32'd200);
      push(c0 + 10, K_FRQ, 32'd300);
      push(c0 + 11, K_CTR, 32'd0);
      push(c0 + 12, K_DONE, 32'd0);
      pulse_start();
      wait_cyc(c0 + 7);
      cog_setfrq = 1'b1;
      cog_data   = 32'h0000_DEAD;
      @(negedge clk_cog);
      cog_setfrq = 1'b0;
      cog_data   = 32'd0;
      wait_cyc(c0 + 14);

      // ena abort during hold, then replay from step 0
      c0 = cyc;
      push(c0 + 2, K_CTR, CFG_CTR);
      push(c0 + 3, K_PHS, 32'd0);
      push(c0 + 4, K_FRQ, 32'd100);
      pulse_start();
      wait_cyc(c0 + 5);
      ena = 1'b0;
      @(negedge clk_cog);
      ena = 1'b1;
      check("busy_after_ena_abort", 64'(busy), 64'd0);
      wait_cyc(c0 + 14);
      c1 = cyc;
      push_basic(c1);
      pulse_start();
      wait_cyc(c1 + 13);

      // asynchronous reset mid-run, then start together with stop
      c0 = cyc;
      push(c0 + 2, K_CTR, CFG_CTR);
      push(c0 + 3, K_PHS, 32'd0);
      push(c0 + 4, K_FRQ, 32'd100);
      pulse_start();
      wait_cyc(c0 + 4);
      #2 nres = 1'b0;
      #1 check("async_reset_outputs", 64'({setctr, setfrq, setphs, done, busy, step, data}), 64'd0);
      @(negedge clk_cog);
      @(negedge clk_cog);
      nres = 1'b1;
      @(negedge clk_cog);
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk_cog);
      start = 1'b0;
      stop  = 1'b0;
      check("start_stop_busy_0", 64'(busy), 64'd0);
      @(negedge clk_cog);
      check("start_stop_busy_1", 64'(busy), 64'd0);

      // eight back-to-back steps, wrap to 0, then an edited entry 0 holds
      for (int i = 0; i < DEPTH; i++) prog(i, 32'h1000 + 32'(i), 16'd1);
      cfg_last = 3'd7;
      cfg_loop = 1'b1;
      c0 = cyc;
      push(c0 + 2, K_CTR, CFG_CTR);
      push(c0 + 3, K_PHS, 32'd0);
      for (int i = 0; i < DEPTH; i++) push(c0 + 4 + i, K_FRQ, 32'h1000 + 32'(i));
      push(c0 + 12, K_FRQ, 32'h1000);
      push(c0 + 14, K_CTR, 32'd0);
      push(c0 + 15, K_DONE, 32'd0);
      pulse_start();
      wait_cyc(c0 + 6);
      prog(0, 32'h1000, 16'd3);
      wait_cyc(c0 + 10);
      check("step_before_wrap", 64'(step), 64'd7);
      wait_cyc(c0 + 11);
      check("step_after_wrap", 64'(step), 64'd0);
      wait_cyc(c0 + 12);
      stop = 1'b1;
      @(negedge clk_cog);
      stop = 1'b0;
      cfg_loop = 1'b0;
      wait_cyc(c0 + 17);
      check("busy_end_wrap", 64'(busy), 64'd0);

      repeat (3) @(negedge clk_cog);
      check("scoreboard_empty", 64'(q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
